uart_tx_pacer_fifo: RTL

//  Rate-matching buffer between the sobel stage and uart_tx. Sobel emits result bytes as
//  po_flag/po_data bursts faster than the UART line can drain them. uart_tx has no busy output.

---
 rtl/sobel_uart_pkg.sv | 20 ++
 rtl/sdp_ram_rdreg.sv | 31 +++
 rtl/uart_tx_pacer_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/sobel_uart_pkg.sv
// Shared UART timing constants for the sobel -> uart datapath (uart_rx, uart_tx, pacer).
// Cycle counts per bit and per frame are derived here so all blocks agree on line timing.
package sobel_uart_pkg;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int UART_BPS   = 9600;
    localparam int FRAME_BITS = 10;

    function automatic int bit_cycles(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    function automatic int byte_cycles(input int clk_freq, input int bps, input int frame_bits);
        return bit_cycles(clk_freq, bps) * frame_bits;
    endfunction

    localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ, UART_BPS);
    localparam int BYTE_CYCLES = byte_cycles(CLK_FREQ, UART_BPS, FRAME_BITS);

endpackage

// File: rtl/sdp_ram_rdreg.sv
// Simple dual-port byte RAM: one write port, one registered read port, no storage reset.
// Latency: rd_data valid the cycle after rd_en; holds its value while rd_en is low.
// Backpressure: none; caller guarantees addresses and enables are legal.
module sdp_ram_rdreg #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_pacer_fifo.sv
// Buffers sobel result bytes and re-issues them to uart_tx as 1-cycle pulses, one frame apart.
// Latency: write in cycle 0 into an idle empty FIFO -> po_flag in cycle 3; pulse spacing BYTE_CYCLES+2.
// Backpressure: none upstream; bytes arriving while full are dropped and flagged in sticky overflow.
module uart_tx_pacer_fifo #(
    parameter int ADDR_W     = 10,
    parameter int CLK_FREQ   = sobel_uart_pkg::CLK_FREQ,
    parameter int UART_BPS   = sobel_uart_pkg::UART_BPS,
    parameter int FRAME_BITS = sobel_uart_pkg::FRAME_BITS
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [7:0]      pi_data,
    input  logic            pi_flag,
    output logic [7:0]      po_data,
    output logic            po_flag,
    output logic            fifo_full,
    output logic            fifo_empty,
    output logic            overflow,
    output logic [ADDR_W:0] level
);

    localparam int BYTE_CYCLES = sobel_uart_pkg::byte_cycles(CLK_FREQ, UART_BPS, FRAME_BITS);
    localparam int CNT_W       = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } pacer_state_t;

    pacer_state_t state, state_nxt;

    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]      rd_q;
    logic            wr_en, rd_en, launch;

    // Full is the registered flag, so a read in the same cycle never frees a slot for this write.
    assign wr_en      = pi_flag && !fifo_full;
    assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_en};
    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_en};
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    sdp_ram_rdreg #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (pi_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_q)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en  = (state == IDLE) && !fifo_empty;
        launch = (state == LAUNCH);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
            po_data    <= 8'h00;
            po_flag    <= 1'b0;
            cnt        <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            level      <= level_nxt;
            fifo_full  <= (level_nxt == DEPTH);
            fifo_empty <= (level_nxt == '0);
            if (pi_flag && fifo_full) begin
                overflow <= 1'b1;
            end
            po_flag <= launch;
            // The frame wait starts on the same edge that raises po_flag.
            if (launch) begin
                po_data <= rd_q;
                cnt     <= CNT_W'(BYTE_CYCLES - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
